writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/rv32_isa.sv | 13 +
 rtl/writeback_arbiter_if.sv | 33 +++
 rtl/writeback_arbiter.sv | 119 +++++++++++
 tb/tb_writeback_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_isa.sv
// RV32 register-file widths and the writeback queue entry shared by the
// writeback path.
package rv32_isa;

    localparam int unsigned RegWidth     = 32;
    localparam int unsigned RegAddrWidth = 5;

    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegWidth-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback arbiter port bundle: result sources in, register-file write port out.
interface writeback_arbiter_if
    import rv32_isa::*;
#(
    parameter int unsigned NSrc  = 2,
    parameter int unsigned Depth = 4
);
    localparam int unsigned CntWidth = $clog2(Depth) + 1;

    logic [NSrc-1:0]                   iValid;
    logic [NSrc-1:0][RegAddrWidth-1:0] iAddr;
    logic [NSrc-1:0][RegWidth-1:0]     iData;
    logic [NSrc-1:0]                   oReady;
    logic                              iStall;
    logic                              iFlush;
    logic                              oWriteEn;
    logic [RegAddrWidth-1:0]           oAddr_Rd;
    logic [RegWidth-1:0]               oRd;
    logic [CntWidth-1:0]               oCount;

    // Drives results and pipeline control into the arbiter.
    modport master (
        output iValid, iAddr, iData, iStall, iFlush,
        input  oReady, oWriteEn, oAddr_Rd, oRd, oCount
    );

    // The arbiter itself.
    modport slave (
        input  iValid, iAddr, iData, iStall, iFlush,
        output oReady, oWriteEn, oAddr_Rd, oRd, oCount
    );

endinterface

// File: rtl/writeback_arbiter.sv
// Arbitrates NSrc result sources into a FIFO feeding the register-file write port.
// Define WRITEBACK_RR_EN for round-robin arbitration; otherwise fixed priority.
module writeback_arbiter
    import rv32_isa::*;
#(
    parameter int unsigned NSrc  = 2,
    parameter int unsigned Depth = 4
) (
    input  logic                iClk,
    input  logic                nRst,
    writeback_arbiter_if.slave  bus
);

    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam int unsigned SrcWidth = $clog2(NSrc);

    generate
        if (NSrc < 2 || NSrc > 4) begin : g_bad_nsrc
            $error("writeback_arbiter: NSrc must be 2..4");
        end
        if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
            $error("writeback_arbiter: Depth must be a power of 2 >= 2");
        end
    endgenerate

    wb_entry_t           mem [Depth];
    logic [PtrWidth-1:0] rd_ptr;
    logic [PtrWidth-1:0] wr_ptr;
    logic [CntWidth-1:0] count;
    logic [SrcWidth-1:0] grant_idx;
    logic                any_valid;
    logic                can_accept;
    logic                hs;
    logic                push;
    logic                pop;
    wb_entry_t           in_entry;

`ifdef WRITEBACK_RR_EN
    logic [SrcWidth-1:0] rr_ptr;

    // Search starts just after the last winner; the nearest requester wins.
    always_comb begin
        grant_idx = '0;
        for (int off = int'(NSrc); off >= 1; off--) begin
            if (bus.iValid[SrcWidth'((int'(rr_ptr) + off) % int'(NSrc))]) begin
                grant_idx = SrcWidth'((int'(rr_ptr) + off) % int'(NSrc));
            end
        end
    end

    // Pointer only moves on a completed handshake.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            rr_ptr <= SrcWidth'(NSrc - 1);
        end else if (hs) begin
            rr_ptr <= grant_idx;
        end
    end
`else
    // Lowest asserted index wins.
    always_comb begin
        grant_idx = '0;
        for (int i = int'(NSrc) - 1; i >= 0; i--) begin
            if (bus.iValid[SrcWidth'(i)]) begin
                grant_idx = SrcWidth'(i);
            end
        end
    end
`endif

    // No full-passthrough: a full queue refuses even when the head pops this cycle.
    always_comb begin
        any_valid    = |bus.iValid;
        can_accept   = nRst && !bus.iFlush && (count < CntWidth'(Depth));
        bus.oReady   = (can_accept && any_valid) ? (NSrc'(1) << grant_idx) : '0;
        hs           = can_accept && any_valid;
        in_entry     = '{addr: bus.iAddr[grant_idx], data: bus.iData[grant_idx]};
        push         = hs && (in_entry.addr != '0);
        pop          = nRst && (count != '0) && !bus.iStall && !bus.iFlush;
        bus.oWriteEn = pop;
        bus.oCount   = count;
        bus.oAddr_Rd = mem[rd_ptr].addr;
        bus.oRd      = mem[rd_ptr].data;
    end

    // Queue bookkeeping; flush wins over any push or pop that edge.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.iFlush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PtrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_writeback_arbiter;

    localparam int NSRC  = 2;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic iClk;
    logic nRst;

    writeback_arbiter_if #(.NSrc(NSRC), .Depth(DEPTH)) bus ();

    writeback_arbiter #(.NSrc(NSRC), .Depth(DEPTH)) dut (
        .iClk (iClk),
        .nRst (nRst),
        .bus  (bus)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    int n_checks = 0;
    int n_errors = 0;

    ent_t q[$];
    int   last_grant = NSRC - 1;

    logic [NSRC-1:0] s_rdy;
    logic            s_we;
    logic [4:0]      s_addr;
    logic [31:0]     s_data;
    logic [2:0]      s_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Which source the rules say should be granted right now.
    function automatic logic [NSRC-1:0] model_ready();
        logic [NSRC-1:0] r;
        int k;
        r = '0;
        if (!nRst || bus.iFlush || q.size() >= DEPTH) return r;
`ifdef WRITEBACK_RR_EN
        for (int off = 1; off <= NSRC; off++) begin
            k = (last_grant + off) % NSRC;
            if (bus.iValid[k]) begin
                r[k] = 1'b1;
                return r;
            end
        end
`else
        for (k = 0; k < NSRC; k++) begin
            if (bus.iValid[k]) begin
                r[k] = 1'b1;
                return r;
            end
        end
`endif
        return r;
    endfunction

    // Check one cycle's outputs, then advance the model across the next edge.
    task automatic cycle();
        logic [NSRC-1:0] er;
        logic            ew;
        #1;
        er = model_ready();
        ew = nRst && (q.size() != 0) && !bus.iStall && !bus.iFlush;
        s_rdy  = bus.oReady;
        s_we   = bus.oWriteEn;
        s_addr = bus.oAddr_Rd;
        s_data = bus.oRd;
        s_cnt  = bus.oCount;
        check("ready", 64'(s_rdy), 64'(er));
        check("write_en", 64'(s_we), 64'(ew));
        check("count", 64'(s_cnt), 64'(q.size()));
        if (q.size() != 0) begin
            check("head_addr", 64'(s_addr), 64'(q[0].a));
            check("head_data", 64'(s_data), 64'(q[0].d));
        end
        @(posedge iClk);
        if (!nRst || bus.iFlush) begin
            q.delete();
            if (!nRst) last_grant = NSRC - 1;
        end else begin
            if (ew) void'(q.pop_front());
            for (int k = 0; k < NSRC; k++) begin
                if (er[k]) begin
                    last_grant = k;
                    if (bus.iAddr[k] != 5'd0) q.push_back('{a: bus.iAddr[k], d: bus.iData[k]});
                end
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.iValid = '0;
        bus.iAddr  = '0;
        bus.iData  = '0;
        bus.iStall = 1'b0;
        bus.iFlush = 1'b0;
    endtask

    initial begin
        logic [NSRC-1:0] prev;

        nRst = 1'b0;
        idle_inputs();
        bus.iValid = 2'b11;
        bus.iAddr  = {5'd3, 5'd4};
        #8;
        check("rst_ready", 64'(bus.oReady), 64'd0);
        check("rst_we", 64'(bus.oWriteEn), 64'd0);
        check("rst_count", 64'(bus.oCount), 64'd0);
        idle_inputs();
        #4 nRst = 1'b1;
        @(posedge iClk);
        #1;
        cycle();

        // Single source into empty queue.
        bus.iValid = 2'b01; bus.iAddr[0] = 5'd5; bus.iData[0] = 32'hDEADBEEF;
        cycle();
        check("single_ready", 64'(s_rdy), 64'd1);
        idle_inputs();
        cycle();
        check("single_we", 64'(s_we), 64'd1);
        check("single_addr", 64'(s_addr), 64'd5);
        check("single_data", 64'(s_data), 64'hDEADBEEF);
        cycle();
        check("single_cnt", 64'(s_cnt), 64'd0);

        // Write to x0 is accepted and dropped.
        bus.iValid = 2'b10; bus.iAddr[1] = 5'd0; bus.iData[1] = 32'h1234;
        cycle();
        check("x0_ready", 64'(s_rdy), 64'd2);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("x0_we", 64'(s_we), 64'd0);
            check("x0_cnt", 64'(s_cnt), 64'd0);
        end

        // Fill while stalled, then drain in order.
        bus.iStall = 1'b1; bus.iValid = 2'b01;
        for (int r = 1; r <= 5; r++) begin
            bus.iAddr[0] = 5'(r); bus.iData[0] = 32'h100 + 32'(r);
            cycle();
        end
        check("full_ready", 64'(s_rdy), 64'd0);
        check("full_cnt", 64'(s_cnt), 64'd4);
        bus.iStall = 1'b0;
        cycle();
        check("drain1_addr", 64'(s_addr), 64'd1);
        check("drain1_ready", 64'(s_rdy), 64'd0);
        cycle();
        check("drain2_addr", 64'(s_addr), 64'd2);
        check("drain2_ready", 64'(s_rdy), 64'd1);
        bus.iValid = '0;
        for (int r = 3; r <= 5; r++) begin
            cycle();
            check("drain_we", 64'(s_we), 64'd1);
            check("drain_addr", 64'(s_addr), 64'(r));
        end
        cycle();
        check("drain_cnt", 64'(s_cnt), 64'd0);

        // Contention while stalled.
        bus.iStall = 1'b1; bus.iValid = 2'b11;
        bus.iAddr  = {5'd9, 5'd7}; bus.iData = {32'hB1, 32'hA0};
        prev = '0;
        for (int i = 0; i < 4; i++) begin
            cycle();
`ifdef WRITEBACK_RR_EN
            if (i > 0) check("rr_alt", 64'(s_rdy), 64'(~prev));
`else
            check("fixed_grant", 64'(s_rdy), 64'd1);
`endif
            prev = s_rdy;
        end
        bus.iFlush = 1'b1; bus.iValid = '0;
        cycle();
        bus.iFlush = 1'b0;

        // Flush with three queued and a presented result.
        bus.iValid = 2'b01;
        for (int r = 1; r <= 3; r++) begin
            bus.iAddr[0] = 5'(r + 10); bus.iData[0] = 32'(r);
            cycle();
        end
        bus.iFlush = 1'b1;
        cycle();
        check("flush_ready", 64'(s_rdy), 64'd0);
        idle_inputs();
        cycle();
        check("flush_cnt", 64'(s_cnt), 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("flush_we", 64'(s_we), 64'd0);
        end

        // Async reset mid-cycle with two entries queued.
        bus.iStall = 1'b1; bus.iValid = 2'b01;
        for (int r = 1; r <= 2; r++) begin
            bus.iAddr[0] = 5'(r + 20); bus.iData[0] = 32'(r);
            cycle();
        end
        idle_inputs();
        #2;
        check("pre_rst_we", 64'(bus.oWriteEn), 64'd1);
        nRst = 1'b0;
        #1;
        check("arst_cnt", 64'(bus.oCount), 64'd0);
        check("arst_we", 64'(bus.oWriteEn), 64'd0);
        q.delete();
        last_grant = NSRC - 1;
        @(posedge iClk);
        #3 nRst = 1'b1;
        cycle();
        check("post_rst_we", 64'(s_we), 64'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bus.iValid = NSRC'($urandom_range(0, 3));
            for (int k = 0; k < NSRC; k++) begin
                bus.iAddr[k] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                bus.iData[k] = $urandom;
            end
            bus.iStall = ($urandom_range(0, 9) < 3);
            bus.iFlush = ($urandom_range(0, 24) == 0);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 6; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
